rfphoenix_vbranch_eval: RTL
===========================

// Module: rfphoenix_vbranch_eval
// PURPOSE
//  Multi-lane, pipelined branch-condition evaluator for the vector issue path. Each lane compares
//  integer or IEEE-754 operands under one condition code, masks by active lanes, and reduces to a
//  taken flag. Sits between operand read and the branch resolver; valid/ready on both sides.
// PARAMETERS
//  NLANES  4   number of lanes evaluated in parallel (1..16)
//  WID     32  lane width in bits (8..64)
//  FPEXP   8   FP exponent width; mantissa = WID-1-FPEXP
//  TAGW    6   width of pass-through tag (branch id)
// PORTS
//  clk_i        in   1                   clock, all state on rising edge
//  rst_ni       in   1                   synchronous reset, active-low
//  flush_i      in   1                   kill all in-flight evaluations
//  in_valid_i   in   1                   request valid
//  in_ready_o   out  1                   request accepted when valid&ready at edge
//  tag_i        in   TAGW                branch id, returned unchanged
//  fp_i         in   1                   1=FP condition set, 0=integer set
//  cnd_i        in   3                   condition code (see BEHAVIOUR)
//  red_i        in   2                   reduction: 0 ANY,1 ALL,2 NONE,3 LANE0
//  bitidx_i     in   $clog2(WID)         bit index for BBS
//  act_i        in   NLANES              active-lane mask
//  a_i,b_i      in   NLANES*WID          lane operands, lane k = [k*WID +: WID]
//  out_valid_o  out  1                   result valid
//  out_ready_i  in   1                   consumer accepts result
//  tag_o        out  TAGW                tag of result
//  taken_o      out  1                   reduced branch decision
//  match_o      out  NLANES              per-lane condition result AND act
//  count_o      out  $clog2(NLANES+1)    popcount(match_o)
// BEHAVIOUR
//  - Integer cnd: 0 LT signed,1 GE signed,2 LTU,3 GEU,4 BBS (a[bitidx]),5 EQ,6 NE,7 ->0.
//  - FP cnd: 0 EQ,1 NE (true if either NaN),2 LT,3 LE,4 GT,5 UNORD,6/7 ->0.
//    EQ/LT/LE/GT false if either operand NaN; +0 == -0; compare by sign-magnitude, no ALU reuse.
//  - NaN: exponent all-ones and mantissa non-zero; sNaN treated as NaN, no exception flag.
//  - Reduction over act_i: ANY = |match; ALL = &(match|~act) and act!=0 (empty -> 0);
//    NONE = ~|match (empty -> 1); LANE0 = match[0].
//  - Pipeline: S1 registers request; S2 registers lane results, reduction, count. Latency 2:
//    accepted at edge N -> out_valid_o at edge N+2 if no backpressure. Throughput 1/clk.
//  - advance = ~out_valid_o | out_ready_i; in_ready_o = advance (combinational). When
//    ~advance both stages hold; outputs stable while out_valid_o & ~out_ready_i.
//  - S1 bubble moves into S2 when advancing: out_valid_o drops after consumption if none behind.
//  - flush_i at an edge: both stage valids cleared; concurrent in_valid_i&in_ready_o discarded;
//    data regs may keep stale values, out_valid_o=0 next cycle. flush beats advance.
//  - Reset (rst_ni=0 at edge): out_valid_o=0, taken_o=0, match_o=0, count_o=0, tag_o=0,
//    internal valid=0; in_ready_o=1 after reset. Reset mid-operation drops all results.
//  - Out-of-range bitidx impossible by width; WID not power of 2: bitidx>=WID gives 0.
//  - match_o/count_o/taken_o only meaningful when out_valid_o=1; registered, no comb path from in.
// TESTING
//  1 INT: NLANES=4, cnd=0, a={-1,5,3,0x80000000}, b={0,5,4,0}, act=F, ANY -> match=4'b1101
//    (lane0 LSB), count=3, taken=1, out_valid two edges after accept.
//  2 FP: cnd=1 NE, lane0 a=0x7FC00000(NaN) b=0x3F800000, lane1 a=0x00000000 b=0x80000000,
//    act=3, ALL -> match=2'b01, taken=0; cnd=0 EQ same data -> match=2'b10.
//  3 Reduction: act=0, all lanes would match -> ANY=0, ALL=0, NONE=1, LANE0=0.
//  4 Backpressure: 4 back-to-back requests, out_ready_i=0 for 3 cycles -> in_ready_o low after
//    pipe full, results emitted in order, tags 1..4, none lost or duplicated.
//  5 Flush: accept tags 7,8; flush on cycle tag 9 offered -> no out_valid for 7,8,9; tag 10
//    accepted next cycle appears 2 cycles later.
//  6 Reset mid-stream: rst_ni low 1 cycle with both stages full -> out_valid_o=0, all outputs 0,
//    in_ready_o=1 the following cycle.

Source files
------------

// File: rtl/rfphoenix_vbranch_eval.sv
// rfphoenix_vbranch_eval
// Two-stage vector branch-condition evaluator. Stage 1 captures the request.
// Stage 2 captures the per-lane condition results, the reduced taken flag and
// the match popcount. Both stages move together under a single advance
// signal that is driven by the consumer handshake.
module rfphoenix_vbranch_eval #(
    parameter int NLANES = 4,
    parameter int WID    = 32,
    parameter int FPEXP  = 8,
    parameter int TAGW   = 6,
    localparam int BIW   = $clog2(WID),
    localparam int CNTW  = $clog2(NLANES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TAGW-1:0]       tag_i,
    input  logic                  fp_i,
    input  logic [2:0]            cnd_i,
    input  logic [1:0]            red_i,
    input  logic [BIW-1:0]        bitidx_i,
    input  logic [NLANES-1:0]     act_i,
    input  logic [NLANES*WID-1:0] a_i,
    input  logic [NLANES*WID-1:0] b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TAGW-1:0]       tag_o,
    output logic                  taken_o,
    output logic [NLANES-1:0]     match_o,
    output logic [CNTW-1:0]       count_o
);

    localparam int MANW = WID - 1 - FPEXP;

    // Evaluate one lane. FP ordering uses sign-magnitude, so +0 and -0 compare equal.
    function automatic logic lane_eval(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                       input logic fp, input logic [2:0] cnd,
                                       input logic [BIW-1:0] idx);
        logic           a_nan, b_nan, unord, both_zero, mag_eq, mag_lt, f_eq, f_lt;
        logic [WID-1:0] one_hot;
        logic           res;
        a_nan     = (&a[WID-2 -: FPEXP]) & (|a[MANW-1:0]);
        b_nan     = (&b[WID-2 -: FPEXP]) & (|b[MANW-1:0]);
        unord     = a_nan | b_nan;
        both_zero = ~(|a[WID-2:0]) & ~(|b[WID-2:0]);
        mag_eq    = (a[WID-2:0] == b[WID-2:0]);
        mag_lt    = (a[WID-2:0] <  b[WID-2:0]);
        f_eq      = both_zero | (mag_eq & (a[WID-1] == b[WID-1]));
        if (both_zero) begin
            f_lt = 1'b0;
        end else if (a[WID-1] != b[WID-1]) begin
            f_lt = a[WID-1];
        end else if (a[WID-1]) begin
            f_lt = ~mag_lt & ~mag_eq;
        end else begin
            f_lt = mag_lt;
        end
        // An index at or beyond WID shifts the single bit out, so BBS yields 0.
        one_hot = {{(WID-1){1'b0}}, 1'b1} << idx;
        res = 1'b0;
        if (fp) begin
            case (cnd)
                3'd0:    res = ~unord & f_eq;
                3'd1:    res = unord | ~f_eq;
                3'd2:    res = ~unord & f_lt;
                3'd3:    res = ~unord & (f_lt | f_eq);
                3'd4:    res = ~unord & ~f_lt & ~f_eq;
                3'd5:    res = unord;
                default: res = 1'b0;
            endcase
        end else begin
            case (cnd)
                3'd0:    res = ($signed(a) <  $signed(b));
                3'd1:    res = ($signed(a) >= $signed(b));
                3'd2:    res = (a <  b);
                3'd3:    res = (a >= b);
                3'd4:    res = |(a & one_hot);
                3'd5:    res = (a == b);
                3'd6:    res = (a != b);
                default: res = 1'b0;
            endcase
        end
        return res;
    endfunction

    logic                  advance;
    logic                  s1_valid_d, s1_valid_q;
    logic [TAGW-1:0]       s1_tag_d, s1_tag_q;
    logic                  s1_fp_d, s1_fp_q;
    logic [2:0]            s1_cnd_d, s1_cnd_q;
    logic [1:0]            s1_red_d, s1_red_q;
    logic [BIW-1:0]        s1_bitidx_d, s1_bitidx_q;
    logic [NLANES-1:0]     s1_act_d, s1_act_q;
    logic [NLANES*WID-1:0] s1_a_d, s1_a_q;
    logic [NLANES*WID-1:0] s1_b_d, s1_b_q;
    logic                  s2_valid_d, s2_valid_q;
    logic [TAGW-1:0]       s2_tag_d, s2_tag_q;
    logic                  s2_taken_d, s2_taken_q;
    logic [NLANES-1:0]     s2_match_d, s2_match_q;
    logic [CNTW-1:0]       s2_count_d, s2_count_q;
    logic [NLANES-1:0]     lane_match;
    logic [CNTW-1:0]       match_cnt;
    logic                  red_taken;

    // Lane results, popcount and reduction of the request held in stage 1.
    always_comb begin
        lane_match = '0;
        match_cnt  = '0;
        red_taken  = 1'b0;
        for (int k = 0; k < NLANES; k++) begin
            lane_match[k] = s1_act_q[k] & lane_eval(s1_a_q[k*WID +: WID], s1_b_q[k*WID +: WID],
                                                    s1_fp_q, s1_cnd_q, s1_bitidx_q);
        end
        for (int k = 0; k < NLANES; k++) begin
            match_cnt = match_cnt + CNTW'(lane_match[k]);
        end
        case (s1_red_q)
            2'd0:    red_taken = |lane_match;
            2'd1:    red_taken = (&(lane_match | ~s1_act_q)) & (|s1_act_q);
            2'd2:    red_taken = ~(|lane_match);
            default: red_taken = lane_match[0];
        endcase
    end

    // Next state of both stages: hold by default, flush kills valids, otherwise shift on advance.
    always_comb begin
        advance     = ~s2_valid_q | out_ready_i;
        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_fp_d     = s1_fp_q;
        s1_cnd_d    = s1_cnd_q;
        s1_red_d    = s1_red_q;
        s1_bitidx_d = s1_bitidx_q;
        s1_act_d    = s1_act_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_tag_d    = s2_tag_q;
        s2_taken_d  = s2_taken_q;
        s2_match_d  = s2_match_q;
        s2_count_d  = s2_count_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s1_valid_d  = in_valid_i;
            s1_tag_d    = tag_i;
            s1_fp_d     = fp_i;
            s1_cnd_d    = cnd_i;
            s1_red_d    = red_i;
            s1_bitidx_d = bitidx_i;
            s1_act_d    = act_i;
            s1_a_d      = a_i;
            s1_b_d      = b_i;
            s2_valid_d  = s1_valid_q;
            s2_tag_d    = s1_tag_q;
            s2_taken_d  = red_taken;
            s2_match_d  = lane_match;
            s2_count_d  = match_cnt;
        end
    end

    // Pipeline registers with synchronous active-low reset clearing everything.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_fp_q     <= 1'b0;
            s1_cnd_q    <= '0;
            s1_red_q    <= '0;
            s1_bitidx_q <= '0;
            s1_act_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            s2_taken_q  <= 1'b0;
            s2_match_q  <= '0;
            s2_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_fp_q     <= s1_fp_d;
            s1_cnd_q    <= s1_cnd_d;
            s1_red_q    <= s1_red_d;
            s1_bitidx_q <= s1_bitidx_d;
            s1_act_q    <= s1_act_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_tag_q    <= s2_tag_d;
            s2_taken_q  <= s2_taken_d;
            s2_match_q  <= s2_match_d;
            s2_count_q  <= s2_count_d;
        end
    end

    assign in_ready_o  = advance;
    assign out_valid_o = s2_valid_q;
    assign tag_o       = s2_tag_q;
    assign taken_o     = s2_taken_q;
    assign match_o     = s2_match_q;
    assign count_o     = s2_count_q;

endmodule
